// File: rtl/midi_pkg.sv
// Shared MIDI definitions: line defaults, receiver state encoding and
// status-byte constants reused by the downstream byte-assembly adapter.
package midi_pkg;

    localparam int MIDI_BAUD_DEFAULT = 31250;
    localparam int MIDI_STATUS_BIT   = 7;

    localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;
    localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

endpackage : midi_pkg

// File: rtl/midi_rx_sync.sv
// Two-flop synchronizer for the asynchronous MIDI line; resets to the
// idle-high level so a reset never looks like a start bit.
module midi_rx_sync
    import midi_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : midi_rx_sync

// File: rtl/single_midi_rx.sv
// Single-channel 8N1 MIDI receiver with mid-bit sampling and status-byte flag.
// Define MIDI_RX_FRAMING_ERR_EN to add the frame_err pulse output.
module single_midi_rx
    import midi_pkg::*;
#(
    parameter int BYTE_W          = 8,
    parameter int MIDI_BAUD       = MIDI_BAUD_DEFAULT,
    parameter int MIDI_FRAME_SIZE = 10,
    parameter int SYSCLK_F        = 48000000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              MIDI_IN,
    output logic [BYTE_W-1:0] data_rx,
    output logic              is_command,
    output logic              new_byte_strobe
`ifdef MIDI_RX_FRAMING_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int BIT_TICKS  = SYSCLK_F / MIDI_BAUD;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CNT_W      = $clog2(BIT_TICKS);
    localparam int IDX_W      = $clog2(BYTE_W);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTE_W - 1);

    if (MIDI_FRAME_SIZE != BYTE_W + 2) begin : g_frame_size_check
        $error("single_midi_rx: MIDI_FRAME_SIZE must equal BYTE_W + 2 (8N1 framing)");
    end
    if (SYSCLK_F < 16 * MIDI_BAUD) begin : g_clock_check
        $error("single_midi_rx: SYSCLK_F must be at least 16 * MIDI_BAUD");
    end

    logic              rx_s;
    rx_state_e         state_q;
    logic [CNT_W-1:0]  tick_q;
    logic [IDX_W-1:0]  idx_q;
    logic [BYTE_W-1:0] shift_q;
    logic [BYTE_W-1:0] data_q;
    logic              cmd_q;
    logic              strobe_q;
    logic              ferr_q;

    midi_rx_sync u_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .d_i     (MIDI_IN),
        .q_o     (rx_s)
    );

    // Returning to IDLE at mid-stop leaves half a bit of margin to catch
    // a back-to-back start edge at the nominal frame boundary.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            cmd_q    <= 1'b0;
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        tick_q  <= '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_LAST) begin
                        tick_q  <= '0;
                        idx_q   <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        tick_q <= tick_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (tick_q == BIT_LAST) begin
                        tick_q         <= '0;
                        shift_q[idx_q] <= rx_s;
                        if (idx_q == IDX_LAST) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        tick_q <= tick_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (tick_q == BIT_LAST) begin
                        tick_q <= '0;
                        if (rx_s) begin
                            data_q   <= shift_q;
                            cmd_q    <= shift_q[BYTE_W-1];
                            strobe_q <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_IDLE;
                        end
                    end else begin
                        tick_q <= tick_q + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_rx         = data_q;
    assign is_command      = cmd_q;
    assign new_byte_strobe = strobe_q;

`ifdef MIDI_RX_FRAMING_ERR_EN
    assign frame_err = ferr_q;
`else
    logic unused_ferr;
    assign unused_ferr = ferr_q;
`endif

endmodule : single_midi_rx

// File: tb/tb_single_midi_rx.sv
// Scoreboard bench for single_midi_rx at a reduced clock (32 clk per bit).
module tb_single_midi_rx;

    localparam int CLK_F = 1000000;
    localparam int BIT   = CLK_F / 31250;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       midi = 1'b1;
    logic [7:0] data_rx;
    logic       is_command;
    logic       strobe;
`ifdef MIDI_RX_FRAMING_ERR_EN
    logic       frame_err;
    int         n_ferr = 0;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int strobe_cyc = 0;
    int n_strobe = 0;
    logic prev_strobe = 1'b0;
    logic [7:0] exp_q[$];

    single_midi_rx #(
        .BYTE_W          (8),
        .MIDI_BAUD       (31250),
        .MIDI_FRAME_SIZE (10),
        .SYSCLK_F        (CLK_F)
    ) dut (
        .sys_clk         (clk),
        .sys_rst         (rst),
        .MIDI_IN         (midi),
        .data_rx         (data_rx),
        .is_command      (is_command),
        .new_byte_strobe (strobe)
`ifdef MIDI_RX_FRAMING_ERR_EN
        ,
        .frame_err       (frame_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard: each strobe pops the oldest expected byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (strobe) begin
                n_strobe++;
                strobe_cyc = cyc;
                if (prev_strobe) chk("dbl_strobe", 1, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {24'h0, data_rx}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("data_rx", data_rx, e);
                    chk("is_command", is_command, e[7]);
                end
            end
`ifdef MIDI_RX_FRAMING_ERR_EN
            if (frame_err) n_ferr++;
`endif
        end
        prev_strobe = strobe;
    end

    initial begin
        repeat (12000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic idle_bits(input int n);
        midi = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    // Line is left at the stop-bit level when the task returns.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        midi = 1'b0;
        start_cyc = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            midi = b[i];
            repeat (BIT) @(negedge clk);
        end
        midi = stop_bit;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    initial begin
        int n0;
        int lat;
        repeat (3) @(negedge clk);
        chk("rst_data", data_rx, 8'h00);
        chk("rst_cmd", is_command, 0);
        chk("rst_strobe", strobe, 0);
        rst = 1'b0;
        idle_bits(2);

        send_good(8'h90);
        lat = strobe_cyc - start_cyc;
        chk("latency_window", (lat >= 9 * BIT + BIT / 2 - 1) && (lat <= 9 * BIT + BIT / 2 + 7), 1);
        idle_bits(1);

        send_good(8'h3C);
        idle_bits(3);
        chk("hold_data", data_rx, 8'h3C);
        chk("hold_cmd", is_command, 0);

        n0 = n_strobe;
        send_good(8'h90);
        send_good(8'h3C);
        send_good(8'h7F);
        idle_bits(1);
        chk("b2b_count", n_strobe - n0, 3);

        n0 = n_strobe;
        midi = 1'b0;
        repeat (BIT / 4) @(negedge clk);
        idle_bits(2);
        chk("glitch_nostrobe", n_strobe - n0, 0);
        chk("glitch_data", data_rx, 8'h7F);
        send_good(8'h45);
        idle_bits(1);

        n0 = n_strobe;
        send_frame(8'hA5, 1'b0);
        repeat (4 * BIT) @(negedge clk);
        idle_bits(2);
        chk("ferr_nostrobe", n_strobe - n0, 0);
        chk("ferr_data", data_rx, 8'h45);
`ifdef MIDI_RX_FRAMING_ERR_EN
        chk("ferr_pulses", n_ferr, 1);
`endif
        send_good(8'h80);
        idle_bits(1);

        n0 = n_strobe;
        midi = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            midi = 1'b1;
            repeat (BIT) @(negedge clk);
        end
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_data", data_rx, 8'h00);
        chk("midrst_cmd", is_command, 0);
        chk("midrst_strobe", strobe, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_bits(6);
        chk("midrst_nostrobe", n_strobe - n0, 0);
        send_good(8'h12);
        idle_bits(2);

        chk("queue_empty", exp_q.size(), 0);
        chk("strobe_total", n_strobe, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_single_midi_rx
